// File: rtl/deco_pkg.sv
// Shared types and constants for the decompressor prefetch buffer.
package deco_pkg;

   typedef enum logic [1:0] {StBoot, StRun, StHalt} deco_pfb_state_t;

   localparam int unsigned DecoWidth = 32;
   localparam logic [DecoWidth-1:0] DecoHaltInstr = 32'h1EFF2FE1;

   typedef struct packed {
      logic [DecoWidth-1:0] instr;
      logic [DecoWidth-1:0] pc;
   } deco_pfb_entry_t;

endpackage

// File: rtl/deco_pfb_fifo.sv
// Prefetch buffer entry storage: circular buffer of {instr, pc} with an occupancy count and a
// synchronous flush that wins over push and pop.
module deco_pfb_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [Width-1:0]       push_instr_i,
   input  logic [Width-1:0]       push_pc_i,
   input  logic                   pop_i,
   output logic                   valid_o,
   output logic [$clog2(Depth):0] count_o,
   output logic [Width-1:0]       head_instr_o,
   output logic [Width-1:0]       head_pc_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] instr_q [Depth];
   logic [Width-1:0] pc_q    [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  count_q;
   logic             pop;

   assign valid_o      = (count_q != '0);
   assign pop          = pop_i & valid_o;
   assign count_o      = count_q;
   assign head_instr_o = instr_q[rptr_q];
   assign head_pc_o    = pc_q[rptr_q];

   // Storage is reset too so the head reads as zero straight out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            instr_q[wptr_q] <= push_instr_i;
            pc_q[wptr_q]    <= push_pc_i;
            wptr_q          <= wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(push_i) - CntW'(pop);
      end
   end

endmodule

// File: rtl/deco_prefetch_buffer.sv
// Prefetch buffer between the register-based decompressor and the CPU fetch port.
// Optional halt detection is enabled by defining DECO_PFB_HALT_EN.
module deco_prefetch_buffer
   import deco_pkg::*;
#(
   parameter int unsigned      Width     = 32,
   parameter logic [Width-1:0] PcStep    = Width'(4),
   parameter logic [Width-1:0] StartPc   = '0,
   parameter int unsigned      Depth     = 4,
   parameter int unsigned      DecoLat   = 1,
   parameter logic [Width-1:0] HaltInstr = Width'(DecoHaltInstr)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic [Width-1:0] deco_pc_o,
   input  logic [Width-1:0] deco_instr_i,
   input  logic             cpu_redirect_i,
   input  logic [Width-1:0] cpu_pc_i,
   input  logic             cpu_ready_i,
   output logic             cpu_valid_o,
   output logic [Width-1:0] cpu_instr_o,
   output logic [Width-1:0] cpu_instr_pc_o,
   output logic             halted_o
);

   localparam int unsigned CntW = $clog2(Depth) + 1;

   deco_pfb_state_t  state_q;
   logic [Width-1:0] deco_pc_q;
   logic             halted_q;

   logic [DecoLat-1:0] tag_vld_q, tag_vld_d;
   logic [Width-1:0]   tag_pc_q [DecoLat];
   logic [Width-1:0]   tag_pc_d [DecoLat];

   logic [CntW-1:0] count;
   int unsigned     inflight;
   logic            pop, push, issue, halt_hit;

   always_comb begin
      inflight = 0;
      for (int i = 0; i < int'(DecoLat); i++) begin
         inflight += 32'(tag_vld_q[i]);
      end
   end

   assign pop  = cpu_valid_o & cpu_ready_i;
   assign push = tag_vld_q[DecoLat-1] & ~cpu_redirect_i;

`ifdef DECO_PFB_HALT_EN
   assign halt_hit = push & (deco_instr_i == HaltInstr);
`else
   assign halt_hit = 1'b0;
   logic unused_halt;
   assign unused_halt = ^HaltInstr;
`endif

   // Credit: buffered plus in-flight entries may never exceed the FIFO depth.
   assign issue = (state_q == StRun) & ~cpu_redirect_i & ~halt_hit &
                  ((32'(count) + inflight - 32'(pop)) < Depth);

   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_pc_d     = tag_pc_q;
      tag_vld_d[0] = issue;
      tag_pc_d[0]  = deco_pc_q;
      for (int i = 1; i < int'(DecoLat); i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_pc_d[i]  = tag_pc_q[i-1];
      end
      if (cpu_redirect_i) begin
         tag_vld_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_vld_q <= '0;
         for (int i = 0; i < int'(DecoLat); i++) begin
            tag_pc_q[i] <= '0;
         end
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_pc_q  <= tag_pc_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StBoot;
         deco_pc_q <= StartPc;
         halted_q  <= 1'b0;
      end else if (cpu_redirect_i) begin
         state_q   <= StRun;
         deco_pc_q <= cpu_pc_i;
         halted_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StBoot: state_q <= StRun;
            StRun: begin
               if (halt_hit) begin
                  state_q  <= StHalt;
                  halted_q <= 1'b1;
               end
            end
            default: ;
         endcase
         if (issue) begin
            deco_pc_q <= deco_pc_q + PcStep;
         end
      end
   end

   assign deco_pc_o = deco_pc_q;
   assign halted_o  = halted_q;

   deco_pfb_fifo #(
      .Width (Width),
      .Depth (Depth)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (cpu_redirect_i),
      .push_i       (push),
      .push_instr_i (deco_instr_i),
      .push_pc_i    (tag_pc_q[DecoLat-1]),
      .pop_i        (cpu_ready_i),
      .valid_o      (cpu_valid_o),
      .count_o      (count),
      .head_instr_o (cpu_instr_o),
      .head_pc_o    (cpu_instr_pc_o)
   );

endmodule

// File: tb/tb_deco_prefetch_buffer.sv
// Directed bench for deco_prefetch_buffer: vector table plus redirect, latency-3 and halt sequences.
module tb_deco_prefetch_buffer;

   localparam logic [31:0] Key  = 32'hA5A5A5A5;
   localparam logic [31:0] Halt = 32'h1EFF2FE1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ready = 1'b0, redirect = 1'b0, halt_mode = 1'b0;
   logic [31:0] cpu_pc = '0;
   logic [31:0] dpc, instr_in, pc_out, instr_out;
   logic        valid, halted;

   logic        ready3 = 1'b0, redirect3 = 1'b0;
   logic [31:0] cpu_pc3 = '0;
   logic [31:0] dpc3, instr3_in, pc3_out, instr3_out, p1, p2;
   logic        valid3, halted3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   deco_prefetch_buffer u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .deco_pc_o      (dpc),
      .deco_instr_i   (instr_in),
      .cpu_redirect_i (redirect),
      .cpu_pc_i       (cpu_pc),
      .cpu_ready_i    (ready),
      .cpu_valid_o    (valid),
      .cpu_instr_o    (instr_out),
      .cpu_instr_pc_o (pc_out),
      .halted_o       (halted)
   );

   deco_prefetch_buffer #(
      .DecoLat (3)
   ) u_dut3 (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .deco_pc_o      (dpc3),
      .deco_instr_i   (instr3_in),
      .cpu_redirect_i (redirect3),
      .cpu_pc_i       (cpu_pc3),
      .cpu_ready_i    (ready3),
      .cpu_valid_o    (valid3),
      .cpu_instr_o    (instr3_out),
      .cpu_instr_pc_o (pc3_out),
      .halted_o       (halted3)
   );

   // Decompressor models: latency 1 and latency 3.
   always_ff @(posedge clk) begin
      if (halt_mode && dpc == 32'h1BC) instr_in <= Halt;
      else                             instr_in <= dpc ^ Key;
      p1        <= dpc3 ^ Key;
      p2        <= p1;
      instr3_in <= p2;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        v;
      logic [31:0] pc;
      logic [31:0] dpc;
   } vec_t;

   vec_t vecs[$];
   int   npop;
   logic [31:0] exp_next;
   logic found;

   initial begin
      // {rst_n, cpu_ready, exp valid, exp head pc, exp deco_pc}
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 32'h04});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h00, 32'h08});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h04, 32'h0C});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h08, 32'h10});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0C, 32'h14});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 32'h18});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 32'h1C});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 32'h20});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 32'h20});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h00, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h00, 32'h04});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 32'h08});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 32'h0C});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 32'h10});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 32'h10});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 32'h10});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h00, 32'h10});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h04, 32'h14});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h08, 32'h18});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0C, 32'h1C});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h10, 32'h20});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h14, 32'h24});

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n = vecs[i].rst;
         ready = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].v));
         check($sformatf("vec%0d deco_pc", i), dpc, vecs[i].dpc);
         check($sformatf("vec%0d halted", i), 32'(halted), 32'h0);
         if (!vecs[i].rst) begin
            check($sformatf("vec%0d reset pc", i), pc_out, 32'h0);
            check($sformatf("vec%0d reset instr", i), instr_out, 32'h0);
         end else if (vecs[i].v) begin
            check($sformatf("vec%0d pc", i), pc_out, vecs[i].pc);
            check($sformatf("vec%0d instr", i), instr_out, vecs[i].pc ^ Key);
         end
      end

      // Redirect with three entries buffered and a simultaneous pop.
      @(negedge clk); rst_n = 1'b0; ready = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      ready = 1'b1; redirect = 1'b1; cpu_pc = 32'h100;
      #1;
      check("redir pre valid", 32'(valid), 32'h1);
      check("redir pre pc", pc_out, 32'h0);
      @(negedge clk); redirect = 1'b0;
      #1;
      check("redir c1 valid", 32'(valid), 32'h0);
      check("redir c1 deco_pc", dpc, 32'h100);
      @(negedge clk); #1;
      check("redir c2 valid", 32'(valid), 32'h0);
      check("redir c2 deco_pc", dpc, 32'h104);
      @(negedge clk); #1;
      check("redir c3 valid", 32'(valid), 32'h1);
      check("redir c3 pc", pc_out, 32'h100);
      check("redir c3 instr", instr_out, 32'h100 ^ Key);
      @(negedge clk); #1;
      check("redir c4 valid", 32'(valid), 32'h1);
      check("redir c4 pc", pc_out, 32'h104);
      check("redir c4 instr", instr_out, 32'h104 ^ Key);

      // Latency 3 with ready toggling 1010.
      @(negedge clk); rst_n = 1'b0; ready3 = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      exp_next = '0;
      npop = 0;
      for (int i = 0; i < 80; i++) begin
         ready3 = (i % 2 == 0);
         #1;
         if (valid3) begin
            check("lat3 pc", pc3_out, exp_next);
            check("lat3 instr", instr3_out, exp_next ^ Key);
            if (ready3) begin
               exp_next = exp_next + 32'h4;
               npop++;
            end
         end
         n_cmp++;
         if ((dpc3 - exp_next) > 32'd16) begin
            n_err++;
            $display("FAIL lat3 credit: outstanding bytes %0d, limit 16", dpc3 - exp_next);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (npop < 30) begin
         n_err++;
         $display("FAIL lat3 throughput: pops %0d, need at least 30", npop);
      end

`ifdef DECO_PFB_HALT_EN
      // Halt pattern at 0x1BC stops issue; redirect resumes.
      @(negedge clk); rst_n = 1'b0; ready = 1'b1; halt_mode = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk); #1;
         if (valid && pc_out == 32'h1BC) found = 1'b1;
      end
      check("halt reached", 32'(found), 32'h1);
      check("halt instr", instr_out, Halt);
      check("halt flag", 32'(halted), 32'h1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         check("halt drained", 32'(valid), 32'h0);
         check("halt deco_pc", dpc, 32'h1C0);
      end
      @(negedge clk); redirect = 1'b1; cpu_pc = 32'h200;
      @(negedge clk); redirect = 1'b0; halt_mode = 1'b0;
      #1;
      check("halt clear", 32'(halted), 32'h0);
      check("halt redir pc", dpc, 32'h200);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
